program_sequencer: RTL and testbench

//  Parametrised successor to the fixed command decoder: a writable program store plus program counter.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/program_store.sv | 57 +++++
 rtl/program_sequencer.sv | 137 +++++++++++++
 tb/tb_program_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: opcodes and the sequencer FSM state encoding.
// Used by both the program sequencer and the datapath.
package calc_pkg;

    localparam int unsigned OP_CLEARLD = 0;
    localparam int unsigned OP_ADDLD   = 1;
    localparam int unsigned OP_ADD     = 2;
    localparam int unsigned OP_SHTR    = 3;
    localparam int unsigned OP_DISP    = 4;
    localparam int unsigned OP_HALT    = 5;
    localparam int unsigned OP_JMP     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Opcodes that travel to the datapath; everything above DISP is handled locally.
    function automatic logic op_is_issued(input int unsigned op);
        return op <= OP_DISP;
    endfunction

endpackage

// File: rtl/program_store.sv
// Instruction store for the program sequencer: synchronous write, registered read,
// and a reset that reloads the default program.
module program_store
    import calc_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter int          ADDR_W  = $clog2(DEPTH),
    parameter int          FUNC_W  = 5,
    parameter int          VALUE_W = 5,
    parameter int unsigned A       = 5,
    parameter int unsigned B       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [FUNC_W-1:0]  wr_func,
    input  logic [VALUE_W-1:0] wr_value,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [FUNC_W-1:0]  rd_func,
    output logic [VALUE_W-1:0] rd_value
);

    localparam int WORD_W = FUNC_W + VALUE_W;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] default_word [DEPTH];
    logic [WORD_W-1:0] rd_word_reg;

    // Default program: CLEARLD A, ADDLD B, ADD, SHTR, DISP, then HALT to the end.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_default
        localparam int unsigned DEF_FUNC  = (int'(gi) <= int'(OP_DISP)) ? int'(gi) : OP_HALT;
        localparam int unsigned DEF_VALUE = (gi == 0) ? A : ((gi == 1) ? B : 0);
        assign default_word[gi] = {FUNC_W'(DEF_FUNC), VALUE_W'(DEF_VALUE)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= default_word[i];
            end
            rd_word_reg <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= {wr_func, wr_value};
            end
            if (rd_en) begin
                rd_word_reg <= mem[rd_addr];
            end
        end
    end

    assign rd_func  = rd_word_reg[WORD_W-1:VALUE_W];
    assign rd_value = rd_word_reg[VALUE_W-1:0];

endmodule

// File: rtl/program_sequencer.sv
// Program counter and fetch/issue FSM: walks the program store and hands
// instructions to the datapath over valid/ready, resolving HALT and JMP locally.
module program_sequencer
    import calc_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter int          ADDR_W  = $clog2(DEPTH),
    parameter int          FUNC_W  = 5,
    parameter int          VALUE_W = 5,
    parameter int unsigned A       = 5,
    parameter int unsigned B       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [FUNC_W-1:0]  wr_func,
    input  logic [VALUE_W-1:0] wr_value,
    output logic [FUNC_W-1:0]  func,
    output logic [VALUE_W-1:0] value,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done,
    output logic               err
);

    seq_state_t        state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    logic               store_wr_en;
    logic               store_rd_en;
    logic [FUNC_W-1:0]  rd_func;
    logic [VALUE_W-1:0] rd_value;
    int unsigned        op;
    logic               issuable;
    logic [ADDR_W-1:0]  jmp_target;

    assign store_wr_en = wr_en && (state_reg == ST_IDLE);
    assign store_rd_en = (state_reg == ST_FETCH);

    program_store #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .FUNC_W  (FUNC_W),
        .VALUE_W (VALUE_W),
        .A       (A),
        .B       (B)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (store_wr_en),
        .wr_addr  (wr_addr),
        .wr_func  (wr_func),
        .wr_value (wr_value),
        .rd_en    (store_rd_en),
        .rd_addr  (pc_reg),
        .rd_func  (rd_func),
        .rd_value (rd_value)
    );

    assign op         = 32'(rd_func);
    assign issuable   = op_is_issued(op);
    assign jmp_target = ADDR_W'(rd_value);

    // The fetched word register doubles as the func/value output, so it only
    // changes in FETCH and stays stable for the whole of ISSUE.
    assign func        = rd_func;
    assign value       = rd_value;
    assign instr_valid = (state_reg == ST_ISSUE) && issuable;
    assign pc          = pc_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else if (stop && (state_reg != ST_IDLE)) begin
            // Abort takes priority over any handshake in the same cycle; pc holds.
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        pc_reg    <= '0;
                        err_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_reg <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (issuable) begin
                        if (instr_ready) begin
                            pc_reg    <= pc_reg + 1'b1;
                            state_reg <= ST_FETCH;
                        end
                    end else if (op == OP_JMP) begin
                        pc_reg    <= jmp_target;
                        state_reg <= ST_FETCH;
                    end else begin
                        // HALT and reserved opcodes both end the run; reserved ones flag err.
                        if (op != OP_HALT) begin
                            err_reg <= 1'b1;
                        end
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: expected instructions are queued when a
// run is launched and compared as each handshake is observed.
module tb_program_sequencer;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int FUNC_W  = 5;
    localparam int VALUE_W = 5;
    localparam int WORD_W  = FUNC_W + VALUE_W;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [FUNC_W-1:0]  wr_func;
    logic [VALUE_W-1:0] wr_value;
    logic [FUNC_W-1:0]  func;
    logic [VALUE_W-1:0] value;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               done;
    logic               err;

    int test_count = 0;
    int fail_count = 0;
    int hs_count   = 0;
    int done_count = 0;

    logic [WORD_W-1:0] exp_q[$];
    logic              prev_stall = 1'b0;
    logic [WORD_W-1:0] prev_word  = '0;

    program_sequencer #(
        .DEPTH   (DEPTH),
        .FUNC_W  (FUNC_W),
        .VALUE_W (VALUE_W),
        .A       (5),
        .B       (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_func     (wr_func),
        .wr_value    (wr_value),
        .func        (func),
        .value       (value),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        test_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Handshake monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_count++;
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", 32'(instr_valid), 1);
                check("hold_word", 32'({func, value}), 32'(prev_word));
            end
            if (instr_valid && instr_ready && !stop) begin
                hs_count++;
                $display("[TB] issue func=%0d value=%0d pc=%0d", func, value, pc);
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 32'(exp_q.size()), 1);
                end else begin
                    logic [WORD_W-1:0] e;
                    e = exp_q.pop_front();
                    check("issue_func", 32'(func), 32'(e[WORD_W-1:VALUE_W]));
                    check("issue_value", 32'(value), 32'(e[VALUE_W-1:0]));
                end
            end
        end
        prev_stall = !rst && instr_valid && !instr_ready && !stop;
        prev_word  = {func, value};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int f, input int v);
        exp_q.push_back({FUNC_W'(f), VALUE_W'(v)});
    endtask

    task automatic push_default();
        push(0, 5); push(1, 3); push(2, 0); push(3, 0); push(4, 0);
    endtask

    task automatic write_word(input int a, input int f, input int v);
        wr_en    = 1'b1;
        wr_addr  = ADDR_W'(a);
        wr_func  = FUNC_W'(f);
        wr_value = VALUE_W'(v);
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 300) begin
            step();
            n++;
        end
        if (!done) check(tag, 32'(done), 1);
    endtask

    task automatic wait_hs(input string tag, input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 300) begin
            step();
            n++;
        end
        if (hs_count < target) check(tag, 32'(hs_count), 32'(target));
    endtask

    initial begin
        int dc;
        int hb;
        rst = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_func = '0; wr_value = '0; instr_ready = 1'b0;

        // 1: reset values, latency, default program
        do_reset();
        check("rst_func", 32'(func), 0);
        check("rst_value", 32'(value), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        instr_ready = 1'b1;
        push_default();
        dc = done_count;
        pulse_start();
        check("lat_fetch_valid", 32'(instr_valid), 0);
        check("lat_fetch_busy", 32'(busy), 1);
        step();
        check("lat_issue_valid", 32'(instr_valid), 1);
        wait_done("t1_done_timeout");
        check("t1_halt_pc", 32'(pc), 5);
        step();
        check("t1_done_once", 32'(done_count - dc), 1);
        check("t1_busy_after", 32'(busy), 0);
        check("t1_done_after", 32'(done), 0);
        check("t1_queue_empty", 32'(exp_q.size()), 0);

        // 2: stall on the second instruction
        push_default();
        hb = hs_count;
        pulse_start();
        wait_hs("t2_hs_timeout", hb + 1);
        instr_ready = 1'b0;
        repeat (3) step();
        check("t2_stall_valid", 32'(instr_valid), 1);
        check("t2_stall_func", 32'(func), 1);
        check("t2_stall_value", 32'(value), 3);
        check("t2_stall_pc", 32'(pc), 1);
        instr_ready = 1'b1;
        wait_done("t2_done_timeout");
        step();
        check("t2_queue_empty", 32'(exp_q.size()), 0);

        // 3: JMP loop, stop after the third accept
        write_word(0, 2, 0);
        write_word(1, 6, 0);
        push(2, 0); push(2, 0); push(2, 0);
        hb = hs_count;
        dc = done_count;
        pulse_start();
        wait_hs("t3_hs_timeout", hb + 3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t3_stop_valid", 32'(instr_valid), 0);
        check("t3_stop_busy", 32'(busy), 0);
        check("t3_stop_pc", 32'(pc), 1);
        step();
        check("t3_no_done", 32'(done_count - dc), 0);
        check("t3_queue_empty", 32'(exp_q.size()), 0);

        // 4: writes while busy are ignored
        do_reset();
        instr_ready = 1'b0;
        pulse_start();
        write_word(0, 3, 7);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_stopped", 32'(busy), 0);
        instr_ready = 1'b1;
        push_default();
        pulse_start();
        wait_done("t4_done_timeout");
        step();
        check("t4_queue_empty", 32'(exp_q.size()), 0);

        // 5: reserved opcode sets sticky err, cleared by next start
        write_word(2, 7, 0);
        push(0, 5); push(1, 3);
        dc = done_count;
        pulse_start();
        wait_done("t5_done_timeout");
        check("t5_err", 32'(err), 1);
        check("t5_halt_pc", 32'(pc), 2);
        step();
        check("t5_done_once", 32'(done_count - dc), 1);
        check("t5_err_sticky", 32'(err), 1);
        push(0, 5); push(1, 3);
        pulse_start();
        check("t5_err_cleared", 32'(err), 0);
        wait_done("t5b_done_timeout");
        step();
        check("t5_queue_empty", 32'(exp_q.size()), 0);

        // 6: pc wrap, then reset mid-run restores the default program
        for (int i = 0; i < DEPTH; i++) write_word(i, 2, 0);
        for (int i = 0; i < 20; i++) push(2, 0);
        hb = hs_count;
        pulse_start();
        wait_hs("t6_hs_timeout", hb + 20);
        check("t6_wrap_pc", 32'(pc), 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_valid", 32'(instr_valid), 0);
        check("t6_rst_pc", 32'(pc), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_queue_drained", 32'(exp_q.size()), 0);
        push_default();
        pulse_start();
        wait_done("t6_done_timeout");
        check("t6_halt_pc", 32'(pc), 5);
        step();
        check("t6_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
